// File: rtl/sbox_rr_sched.sv
// Round-robin scheduler for one shared forward/inverse AES S-box.
// It issues one requester byte per cycle and returns each result with fixed latency.
module sbox_rr_sched #(
    parameter int N_REQ = 4,
    parameter int LAT   = 2,
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_inv,
    output logic [N_REQ-1:0]     req_ready,
    input  logic                 stall,
    output logic [7:0]           sbox_x,
    output logic                 sbox_zf,
    input  logic [7:0]           sbox_y,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_data,
    output logic                 rsp_inv,
    output logic                 busy
);

    logic [ID_W-1:0]        ptr;
    logic                   v0;
    logic [ID_W-1:0]        id0;

    logic [LAT:1]           v_q;
    logic [LAT:1][ID_W-1:0] id_q;
    logic [LAT:1][7:0]      data_q;
    logic [LAT:1]           inv_q;

    logic [N_REQ-1:0]       grant;
    logic                   grant_any;
    logic [ID_W-1:0]        grant_id;
    logic [ID_W-1:0]        ptr_next;
    logic [7:0]             grant_byte;
    logic                   grant_inv;
    logic [ID_W:0]          slot;

    // Rotating priority search starting at ptr. Gating with rst keeps
    // req_ready low for the whole reset interval, not just after the first edge.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        grant     = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        slot      = '0;
        if (!stall && !rst) begin
            for (int j = 0; j < N_REQ; j++) begin
                slot = {1'b0, ptr} + (ID_W+1)'(j);
                if (slot >= (ID_W+1)'(N_REQ)) begin
                    slot = slot - (ID_W+1)'(N_REQ);
                end
                if (!grant_any && req_valid[slot[ID_W-1:0]]) begin
                    grant_any                = 1'b1;
                    grant[slot[ID_W-1:0]]    = 1'b1;
                    grant_id                 = slot[ID_W-1:0];
                end
            end
        end
    end

    // One-hot AND-OR select of the winning byte and direction.
    always_comb begin
        grant_byte = '0;
        grant_inv  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_byte = grant_byte | req_data[8*i +: 8];
                grant_inv  = grant_inv | req_inv[i];
            end
        end
    end

    assign ptr_next  = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    assign req_ready = grant;

    // Issue stage: sbox_x/sbox_zf only change on a grant so the S-box stays quiet when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            v0      <= 1'b0;
            id0     <= '0;
            sbox_x  <= 8'h00;
            sbox_zf <= 1'b0;
        end else if (!stall) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            v0 <= grant_any;
            if (grant_any) begin
                sbox_x  <= grant_byte;
                sbox_zf <= grant_inv;
                id0     <= grant_id;
                ptr     <= ptr_next;
            end
        end
    end

    // Result pipeline; stage 1 closes the only path through the external S-box.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the whole pipeline array is reset because its contents reach rsp_* directly.
            v_q    <= '0;
            id_q   <= '0;
            data_q <= '0;
            inv_q  <= '0;
        end else if (!stall) begin
            v_q[1]    <= v0;
            id_q[1]   <= id0;
            data_q[1] <= sbox_y;
            inv_q[1]  <= sbox_zf;
            for (int k = 2; k <= LAT; k++) begin
                v_q[k]    <= v_q[k-1];
                id_q[k]   <= id_q[k-1];
                data_q[k] <= data_q[k-1];
                inv_q[k]  <= inv_q[k-1];
            end
        end
    end

    // A result held by stall is presented once, on the first cycle after stall drops.
    assign rsp_valid = v_q[LAT] & ~stall;
    assign rsp_id    = id_q[LAT];
    assign rsp_data  = data_q[LAT];
    assign rsp_inv   = inv_q[LAT];
    assign busy      = v0 | (|v_q);

endmodule

// File: tb/tb_sbox_rr_sched.sv
// Self-checking bench for sbox_rr_sched: a behavioural S-box drives sbox_y and a
// queue-based reference predicts grants and responses cycle by cycle.
module tb_sbox_rr_sched;

    localparam int N    = 4;
    localparam int LAT  = 2;
    localparam int ID_W = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [8*N-1:0]     req_data;
    logic [N-1:0]       req_inv;
    logic [N-1:0]       req_ready;
    logic               stall;
    logic [7:0]         sbox_x;
    logic               sbox_zf;
    logic [7:0]         sbox_y;
    logic               rsp_valid;
    logic [ID_W-1:0]    rsp_id;
    logic [7:0]         rsp_data;
    logic               rsp_inv;
    logic               busy;

    sbox_rr_sched #(.N_REQ(N), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_inv   (req_inv),
        .req_ready (req_ready),
        .stall     (stall),
        .sbox_x    (sbox_x),
        .sbox_zf   (sbox_zf),
        .sbox_y    (sbox_y),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_inv   (rsp_inv),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural S-box built from GF(2^8) inversion plus the AES affine map.
    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];
    assign sbox_y = sbox_zf ? inv_tab[sbox_x] : fwd_tab[sbox_x];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] x, input logic inv);
        return inv ? inv_tab[x] : fwd_tab[x];
    endfunction

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       inv;
        int         stamp;
    } exp_t;

    exp_t       q[$];
    int         m_ptr;
    int         adv_cnt;
    int         cycle;
    int         obs_grant;
    int         glog[$];
    int         obs_id[$];
    logic [7:0] obs_data[$];
    logic       obs_inv[$];
    int         obs_cyc[$];

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample at negedge, compare with the model, then advance.
    task automatic tick(input bit rst_mid);
        logic [N-1:0] exp_grant;
        logic         exp_rv;
        int           g;
        @(negedge clk);
        exp_grant = '0;
        g = -1;
        if (!stall && !rst) begin
            for (int j = 0; j < N; j++) begin
                int i = (m_ptr + j) % N;
                if (g < 0 && req_valid[i]) begin
                    g = i;
                    exp_grant[i] = 1'b1;
                end
            end
        end
        check("req_ready", 32'(req_ready), 32'(exp_grant));
        check("busy", 32'(busy), 32'(q.size() != 0));
        exp_rv = !stall && (q.size() > 0) && (adv_cnt - q[0].stamp == LAT + 1);
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (rsp_valid === 1'b1) begin
            obs_id.push_back(int'(rsp_id));
            obs_data.push_back(rsp_data);
            obs_inv.push_back(rsp_inv);
            obs_cyc.push_back(cycle);
        end
        if (exp_rv) begin
            check("rsp_id", 32'(rsp_id), 32'(q[0].id));
            check("rsp_data", 32'(rsp_data), 32'(q[0].data));
            check("rsp_inv", 32'(rsp_inv), 32'(q[0].inv));
            void'(q.pop_front());
        end
        obs_grant = -1;
        for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) obs_grant = i;
        if (obs_grant >= 0) glog.push_back(obs_grant);
        if (g >= 0) begin
            q.push_back('{id: g, data: ref_sbox(req_data[8*g +: 8], req_inv[g]),
                          inv: req_inv[g], stamp: adv_cnt});
            m_ptr = (g + 1) % N;
        end
        if (rst_mid) begin
            #1;
            rst = 1'b1;
            q.delete();
            m_ptr = 0;
            #1;
            check("async_rst_busy", 32'(busy), 32'd0);
            check("async_rst_sbox_x", 32'(sbox_x), 32'd0);
        end
        @(posedge clk);
        if (!stall && !rst) adv_cnt++;
        cycle++;
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic inv);
        req_valid[i]     = 1'b1;
        req_data[8*i +: 8] = d;
        req_inv[i]       = inv;
    endtask

    task automatic drop_granted();
        if (obs_grant >= 0) req_valid[obs_grant] = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && q.size() > 0; k++) tick(0);
        tick(0);
    endtask

    task automatic clear_logs();
        glog.delete(); obs_id.delete(); obs_data.delete(); obs_inv.delete(); obs_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n_id1;
        logic [7:0] held_x;

        rst = 1'b1;
        stall = 1'b0;
        req_valid = '1;
        req_data = 32'h1122_3344;
        req_inv = '0;
        m_ptr = 0; adv_cnt = 0; cycle = 0; obs_grant = -1;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] b;
            b = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            fwd_tab[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
        check("model_fwd_53", 32'(fwd_tab[8'h53]), 32'hED);
        check("model_inv_63", 32'(inv_tab[8'h63]), 32'h00);

        // Reset with every requester pending.
        repeat (2) tick(0);
        check("rst_sbox_x", 32'(sbox_x), 32'h00);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'h00);
        check("rst_rsp_inv", 32'(rsp_inv), 32'd0);
        rst = 1'b0;
        tick(0);
        check("first_grant", 32'(obs_grant), 32'd0);
        req_valid = '0;
        drain();

        // Single forward requests from requester 2.
        clear_logs();
        set_req(2, 8'h53, 1'b0);
        t = cycle;
        tick(0); drop_granted();
        set_req(2, 8'h00, 1'b0);
        tick(0); drop_granted();
        drain();
        check("fwd_count", 32'(obs_id.size()), 32'd2);
        check("fwd_cycle", 32'(obs_cyc[0]), 32'(t + 1 + LAT));
        check("fwd_id", 32'(obs_id[0]), 32'd2);
        check("fwd_53", 32'(obs_data[0]), 32'hED);
        check("fwd_inv", 32'(obs_inv[0]), 32'd0);
        check("fwd_00", 32'(obs_data[1]), 32'h63);

        // Mixed direction back-to-back.
        clear_logs();
        set_req(0, 8'h63, 1'b1);
        set_req(1, 8'h00, 1'b0);
        tick(0); drop_granted();
        tick(0); drop_granted();
        drain();
        check("mix_count", 32'(obs_id.size()), 32'd2);
        check("mix_id0", 32'(obs_id[0]), 32'd0);
        check("mix_data0", 32'(obs_data[0]), 32'h00);
        check("mix_inv0", 32'(obs_inv[0]), 32'd1);
        check("mix_id1", 32'(obs_id[1]), 32'd1);
        check("mix_data1", 32'(obs_data[1]), 32'h63);
        check("mix_b2b", 32'(obs_cyc[1] - obs_cyc[0]), 32'd1);

        // Fairness: bring ptr to 0 via requester 3, then all four valid.
        set_req(3, 8'h01, 1'b0);
        tick(0); drop_granted();
        drain();
        clear_logs();
        for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 1'($urandom));
        repeat (8) begin
            tick(0);
            if (obs_grant >= 0) set_req(obs_grant, 8'($urandom), 1'($urandom));
        end
        for (int k = 0; k < 8; k++) check("rr_order", 32'(glog[k]), 32'(k % N));
        req_valid = 4'b1000;
        repeat (4) begin
            tick(0);
            check("solo_grant", 32'(obs_grant), 32'd3);
            check("solo_ptr", 32'(dut.ptr), 32'd0);
            set_req(3, 8'($urandom), 1'($urandom));
        end
        req_valid = '0;
        drain();

        // Stall holds a result and presents it once; request rising as stall falls is granted.
        clear_logs();
        set_req(1, 8'hA5, 1'b0);
        t = cycle;
        tick(0); drop_granted();
        held_x = 8'hA5;
        stall = 1'b1;
        set_req(3, 8'h3C, 1'b1);
        repeat (4) begin
            tick(0);
            check("stall_sbox_x", 32'(sbox_x), 32'(held_x));
        end
        stall = 1'b0;
        req_valid[3] = 1'b0;
        set_req(0, 8'h10, 1'b1);
        tick(0);
        check("unstall_grant", 32'(obs_grant), 32'd0);
        drop_granted();
        drain();
        n_id1 = 0;
        foreach (obs_id[k]) if (obs_id[k] == 1) n_id1++;
        check("stall_once", 32'(n_id1), 32'd1);
        check("stall_cycle", 32'(obs_cyc[0]), 32'(t + 7));
        check("stall_data", 32'(obs_data[0]), 32'h06);

        // Reset one cycle before the first response.
        clear_logs();
        for (int i = 0; i < 3; i++) set_req(i, 8'($urandom), 1'($urandom));
        tick(0); drop_granted();
        tick(0); drop_granted();
        tick(1); drop_granted();
        tick(0);
        check("midrst_ptr", 32'(dut.ptr), 32'd0);
        rst = 1'b0;
        req_valid = '0;
        repeat (6) tick(0);
        check("midrst_no_rsp", 32'(obs_id.size()), 32'd0);

        // Randomized traffic with stalls, drops and one reset pulse.
        for (int c = 0; c < 400; c++) begin
            stall = ($urandom_range(0, 9) == 0);
            tick(c == 200);
            if (c == 201) rst = 1'b0;
            if (obs_grant >= 0) begin
                if ($urandom_range(0, 1) == 1) set_req(obs_grant, 8'($urandom), 1'($urandom));
                else req_valid[obs_grant] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (i != obs_grant) begin
                    if (!req_valid[i] && $urandom_range(0, 2) == 0) set_req(i, 8'($urandom), 1'($urandom));
                    else if (req_valid[i] && $urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
                end
            end
        end
        stall = 1'b0;
        req_valid = '0;
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
